cpu_2432_xmem_bridge: RTL and testbench

- Sits directly downstream of the cpu_2432 data port and converts each single-cycle 32-bit data access into a sequence of byte cycles on an external asynchronous 8-bit SRAM.
- Inputs: o_daddr, o_dout, o_ram_rd, o_ram_wr from the CPU.
- Outputs: o_din to the CPU's i_din and o_clk_en to the CPU's i_clk_en.
- Stalls the CPU pipeline with o_clk_en until the access completes.

---
 rtl/cpu_2432_xmem_bridge_if.sv | 22 ++
 rtl/cpu_2432_xmem_bridge.sv | 179 +++++++++++++++++
 tb/tb_cpu_2432_xmem_bridge.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_2432_xmem_bridge_if.sv
// CPU data-port bundle between cpu_2432 and its external-memory bridge.
// The bridge takes the slave side: it receives the CPU's address, write data,
// read strobe and byte-lane write enables, and it returns read data and the
// pipeline clock enable.
interface cpu_2432_xmem_bridge_if;
    logic [23:0] i_daddr;
    logic [31:0] i_dout;
    logic        i_ram_rd;
    logic [3:0]  i_ram_wr;
    logic [31:0] o_din;
    logic        o_clk_en;

    modport master (
        output i_daddr, i_dout, i_ram_rd, i_ram_wr,
        input  o_din, o_clk_en
    );

    modport slave (
        input  i_daddr, i_dout, i_ram_rd, i_ram_wr,
        output o_din, o_clk_en
    );
endinterface

// File: rtl/cpu_2432_xmem_bridge.sv
// cpu_2432_xmem_bridge: turns one 32-bit CPU data access into a series of byte
// cycles (SETUP, STROBE x (WAIT_STATES+1), HOLD) on an asynchronous 8-bit
// SRAM. The CPU is stalled through o_clk_en until the DONE cycle.
// Optional feature: define XMEM_RD_BYPASS_EN to keep a one-word last-read
// buffer so that a repeated read of the same word skips the external cycles.
module cpu_2432_xmem_bridge #(
    parameter int WAIT_STATES = 1,   // 0..15
    parameter int XADDR_W     = 24   // 2..24
) (
    input  logic                  i_clk,
    input  logic                  i_rstb,
    cpu_2432_xmem_bridge_if.slave cpu,
    output logic [XADDR_W-1:0]    o_xaddr,
    output logic [7:0]            o_xdata_out,
    input  logic [7:0]            i_xdata_in,
    output logic                  o_xdata_oe,
    output logic                  o_xce_b,
    output logic                  o_xoe_b,
    output logic                  o_xwe_b
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_DONE
    } state_t;

    state_t               r_state, w_state_next;
    logic [XADDR_W-3:0]   r_word;
    logic [31:0]          r_wdata;
    logic [3:0]           r_mask;      // lanes still to be visited
    logic                 r_is_wr;
    logic [1:0]           r_lane;
    logic [3:0]           r_wait;
    logic [31:0]          r_asm;       // read assembly register
    logic [31:0]          r_din;
    logic                 r_xce_b, r_xoe_b, r_xwe_b, r_xdata_oe;

    logic                 w_wr_req, w_req, w_hit, w_clk_en;
    logic                 w_dir_next, w_busy_next;
    logic [3:0]           w_mask_in;
    logic [1:0]           w_first_in, w_first_rem;
    logic [XADDR_W-3:0]   w_word_in;
    logic                 w_unused_ok;

    // Lowest enabled lane of a mask; lanes are visited in ascending order.
    function automatic logic [1:0] first_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // A write wins when read and write are presented together.
    assign w_wr_req    = |cpu.i_ram_wr;
    assign w_req       = cpu.i_ram_rd | w_wr_req;
    assign w_mask_in   = w_wr_req ? cpu.i_ram_wr : 4'b1111;
    assign w_word_in   = cpu.i_daddr[XADDR_W-1:2];
    assign w_first_in  = first_lane(w_mask_in);
    assign w_first_rem = first_lane(r_mask);
    assign w_unused_ok = ^cpu.i_daddr[1:0];

`ifdef XMEM_RD_BYPASS_EN
    logic [31:0]        r_buf;
    logic [XADDR_W-3:0] r_tag;
    logic               r_valid;

    assign w_hit = r_valid & cpu.i_ram_rd & ~w_wr_req & (w_word_in == r_tag);

    // Last-read buffer: filled by each completed read, dropped by a write to its word.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_buf   <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else if (r_state == ST_DONE && !r_is_wr) begin
            r_buf   <= r_asm;
            r_tag   <= r_word;
            r_valid <= 1'b1;
        end else if (r_state == ST_IDLE && w_wr_req && w_word_in == r_tag) begin
            r_valid <= 1'b0;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and CPU clock-enable decode.
    always_comb begin
        w_state_next = r_state;
        w_clk_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clk_en = ~w_req;
                if (w_req) w_state_next = w_hit ? ST_DONE : ST_SETUP;
            end
            ST_SETUP:  w_state_next = ST_STROBE;
            ST_STROBE: if (r_wait == 4'd0) w_state_next = ST_HOLD;
            ST_HOLD:   w_state_next = (|r_mask) ? ST_SETUP : ST_DONE;
            ST_DONE: begin
                w_clk_en     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Direction of the cycle about to start: taken from the request while idle.
    assign w_dir_next  = (r_state == ST_IDLE) ? w_wr_req : r_is_wr;
    assign w_busy_next = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                         (w_state_next == ST_HOLD);

    // SRAM control pins registered from the next state so they are glitch-free.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_xce_b    <= 1'b1;
            r_xoe_b    <= 1'b1;
            r_xwe_b    <= 1'b1;
            r_xdata_oe <= 1'b0;
        end else begin
            r_xce_b    <= ~w_busy_next;
            r_xoe_b    <= ~((w_state_next == ST_STROBE) && !w_dir_next);
            r_xwe_b    <= ~((w_state_next == ST_STROBE) && w_dir_next);
            r_xdata_oe <= w_busy_next && w_dir_next;
        end
    end

    // Request latching, lane sequencing, wait counting and read assembly.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_word  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_is_wr <= 1'b0;
            r_lane  <= '0;
            r_wait  <= '0;
            r_asm   <= '0;
            r_din   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req) begin
                    r_word  <= w_word_in;
                    r_wdata <= cpu.i_dout;
                    r_is_wr <= w_wr_req;
                    r_lane  <= w_first_in;
                    r_mask  <= w_mask_in & ~(4'b0001 << w_first_in);
`ifdef XMEM_RD_BYPASS_EN
                    if (w_hit) r_asm <= r_buf;
`endif
                end
                ST_SETUP: r_wait <= 4'(WAIT_STATES);
                ST_STROBE: begin
                    if (r_wait != 4'd0)  r_wait <= r_wait - 4'd1;
                    else if (!r_is_wr)   r_asm[{r_lane, 3'b000} +: 8] <= i_xdata_in;
                end
                ST_HOLD: if (|r_mask) begin
                    r_lane <= w_first_rem;
                    r_mask <= r_mask & ~(4'b0001 << w_first_rem);
                end
                ST_DONE: if (!r_is_wr) r_din <= r_asm;
                default: ;
            endcase
        end
    end

    assign o_xaddr      = {r_word, r_lane};
    assign o_xdata_out  = r_wdata[{r_lane, 3'b000} +: 8];
    assign o_xdata_oe   = r_xdata_oe;
    assign o_xce_b      = r_xce_b;
    assign o_xoe_b      = r_xoe_b;
    assign o_xwe_b      = r_xwe_b;
    assign cpu.o_din    = r_din;
    assign cpu.o_clk_en = w_clk_en;

endmodule

// File: tb/tb_cpu_2432_xmem_bridge.sv
// Self-checking bench for cpu_2432_xmem_bridge: directed vector table,
// randomized accesses against a word/byte-level reference model, an SRAM
// model, and hand-written reset sequences.
module tb_cpu_2432_xmem_bridge;
    localparam int WS = 1;
    localparam int XW = 24;
`ifdef XMEM_RD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic i_clk  = 1'b0;
    logic i_rstb = 1'b1;
    always #5 i_clk = ~i_clk;

    cpu_2432_xmem_bridge_if cpu_bus();
    logic [XW-1:0] o_xaddr;
    logic [7:0]    o_xdata_out, i_xdata_in;
    logic          o_xdata_oe, o_xce_b, o_xoe_b, o_xwe_b;

    cpu_2432_xmem_bridge #(.WAIT_STATES(WS), .XADDR_W(XW)) dut (
        .i_clk(i_clk), .i_rstb(i_rstb), .cpu(cpu_bus),
        .o_xaddr(o_xaddr), .o_xdata_out(o_xdata_out), .i_xdata_in(i_xdata_in),
        .o_xdata_oe(o_xdata_oe), .o_xce_b(o_xce_b), .o_xoe_b(o_xoe_b), .o_xwe_b(o_xwe_b)
    );

    // SRAM model: drives data only while selected and output-enabled.
    logic [7:0] sram [4096];
    logic [7:0] ref_mem [4096];
    assign i_xdata_in = (!o_xoe_b && !o_xce_b) ? sram[o_xaddr[11:0]] : 8'h00;
    always @(posedge i_clk) if (!o_xce_b && !o_xwe_b) sram[o_xaddr[11:0]] <= o_xdata_out;

    int n_checks = 0, n_fail = 0;

    // Reference model state: CPU-visible read data and the last-read word.
    logic [31:0] model_din = 32'h0;
    bit          model_valid = 1'b0;
    logic [21:0] model_tag = '0;

    // Bus monitor: one record per strobe pulse plus running cycle counters.
    bit          strobe_prev = 1'b0;
    int          mon_strobe = 0, mon_ce = 0, mon_bad = 0;
    logic [23:0] mon_addr [$];
    bit          mon_wr [$];
    logic [7:0]  mon_data [$];
    always @(negedge i_clk) begin : monitor
        bit s;
        s = !o_xoe_b || !o_xwe_b;
        if (s && !strobe_prev) begin
            mon_addr.push_back(o_xaddr);
            mon_wr.push_back(!o_xwe_b);
            mon_data.push_back(o_xdata_out);
        end
        if (s) mon_strobe++;
        if (!o_xce_b) mon_ce++;
        if ((!o_xoe_b && !o_xwe_b) || (s && o_xce_b) || (!o_xwe_b && !o_xdata_oe) ||
            (!o_xoe_b && o_xdata_oe) || (s && o_xaddr[23:12] != 12'h0))
            mon_bad++;
        strobe_prev = s;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        sram[a]    = d;
        ref_mem[a] = d;
    endtask

    task automatic drive(input logic rd, input logic [3:0] wr, input logic [23:0] addr,
                         input logic [31:0] wd);
        cpu_bus.i_ram_rd = rd;
        cpu_bus.i_ram_wr = wr;
        cpu_bus.i_daddr  = addr;
        cpu_bus.i_dout   = wd;
    endtask

    // Idle cycles: CPU runs freely and the SRAM stays deselected.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            drive(1'b0, 4'h0, 24'h0, 32'h0);
            #1;
            check("idle_clk_en", cpu_bus.o_clk_en, 1'b1);
            check("idle_xce_b", o_xce_b, 1'b1);
        end
    endtask

    // One CPU access; expectations come from the byte-level model.
    task automatic access(input logic rd, input logic [3:0] wr, input logic [23:0] addr,
                          input logic [31:0] wd, output int stalls, output logic [31:0] din);
        int a0, s0, c0, b0, nb, exp_st, got;
        bit is_wr, hit, done;
        logic [3:0]  mask;
        logic [11:0] base;
        int lanes [$];
        @(negedge i_clk);
        a0 = mon_addr.size(); s0 = mon_strobe; c0 = mon_ce; b0 = mon_bad;
        drive(rd, wr, addr, wd);
        is_wr = (wr != 4'h0);
        mask  = is_wr ? wr : 4'hF;
        base  = {addr[11:2], 2'b00};
        hit   = BYP && !is_wr && model_valid && (model_tag == addr[23:2]);
        if (!hit) for (int l = 0; l < 4; l++) if (mask[l]) lanes.push_back(l);
        nb     = lanes.size();
        exp_st = 1 + nb * (WS + 3);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (cpu_bus.o_clk_en) done = 1'b1;
            else begin
                stalls++;
                @(negedge i_clk);
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: got clk_en stuck low, expected DONE within 400 cycles");
        end
        @(posedge i_clk);
        #1;
        din = cpu_bus.o_din;
        if (is_wr) begin
            foreach (lanes[i]) ref_mem[base + 12'(lanes[i])] = wd[8*lanes[i] +: 8];
            if (model_tag == addr[23:2]) model_valid = 1'b0;
        end else begin
            model_din   = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
            model_valid = 1'b1;
            model_tag   = addr[23:2];
        end
        got = mon_addr.size() - a0;
        check("stall_cycles", stalls, exp_st);
        check("ext_cycles", got, nb);
        for (int i = 0; i < nb && i < got; i++) begin
            check("xaddr", mon_addr[a0+i], 24'(base) + 24'(lanes[i]));
            check("xdir", mon_wr[a0+i], is_wr);
            if (is_wr) check("xdata", mon_data[a0+i], wd[8*lanes[i] +: 8]);
        end
        check("strobe_cycles", mon_strobe - s0, nb * (WS + 1));
        check("ce_cycles", mon_ce - c0, nb * (WS + 3));
        check("bus_rules", mon_bad - b0, 0);
        check("o_din", din, model_din);
        $display("txn rd=%0d wr=%b addr=%06h wd=%08h stalls=%0d ext=%0d din=%08h",
                 rd, wr, addr, wd, stalls, got, din);
    endtask

    typedef struct {
        logic        rd;
        logic [3:0]  wr;
        logic [23:0] addr;
        logic [31:0] wd;
        int          exp_stalls;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int st, mism;
        logic [31:0] dv;
        logic [23:0] wbase [4];
        wbase = '{24'h000400, 24'h000040, 24'h000020, 24'h0003F0};

        for (int i = 0; i < 4096; i++) poke(i, 8'($urandom));
        poke(12'h400, 8'h11); poke(12'h401, 8'h22); poke(12'h402, 8'h33); poke(12'h403, 8'h44);
        poke(12'h040, 8'h01); poke(12'h041, 8'h02);
        poke(12'h020, 8'h78); poke(12'h021, 8'h56); poke(12'h022, 8'h34); poke(12'h023, 8'h12);

        vecs[0]  = '{1'b1, 4'b0000, 24'h000400, 32'h0,        17,           32'h44332211};
        vecs[1]  = '{1'b0, 4'b0100, 24'h000040, 32'h00AB0000, 5,            32'h44332211};
        vecs[2]  = '{1'b0, 4'b1100, 24'h000040, 32'hCAFE0000, 9,            32'h44332211};
        vecs[3]  = '{1'b1, 4'b0000, 24'h000040, 32'h0,        17,           32'hCAFE0201};
        vecs[4]  = '{1'b1, 4'b0000, 24'h000040, 32'h0,        BYP ? 1 : 17, 32'hCAFE0201};
        vecs[5]  = '{1'b0, 4'b0001, 24'h000040, 32'h000000EE, 5,            32'hCAFE0201};
        vecs[6]  = '{1'b1, 4'b0000, 24'h000040, 32'h0,        17,           32'hCAFE02EE};
        vecs[7]  = '{1'b1, 4'b0010, 24'h000400, 32'h00005500, 5,            32'hCAFE02EE};
        vecs[8]  = '{1'b1, 4'b0000, 24'h000401, 32'h0,        17,           32'h44335511};
        vecs[9]  = '{1'b1, 4'b0000, 24'h000020, 32'h0,        17,           32'h12345678};
        vecs[10] = '{1'b1, 4'b0000, 24'h000020, 32'h0,        BYP ? 1 : 17, 32'h12345678};
        vecs[11] = '{1'b0, 4'b0001, 24'h000020, 32'h000000AA, 5,            32'h12345678};
        vecs[12] = '{1'b1, 4'b0000, 24'h000020, 32'h0,        17,           32'h123456AA};

        // Asynchronous reset, asserted between clock edges.
        drive(1'b0, 4'h0, 24'h0, 32'h0);
        #2 i_rstb = 1'b0;
        #2;
        check("rst_xce_b", o_xce_b, 1'b1);
        check("rst_xoe_b", o_xoe_b, 1'b1);
        check("rst_xwe_b", o_xwe_b, 1'b1);
        check("rst_xdata_oe", o_xdata_oe, 1'b0);
        check("rst_xaddr", o_xaddr, 24'h0);
        check("rst_xdata_out", o_xdata_out, 8'h0);
        check("rst_din", cpu_bus.o_din, 32'h0);
        check("rst_clk_en", cpu_bus.o_clk_en, 1'b1);
        repeat (2) @(negedge i_clk);
        i_rstb = 1'b1;
        idle(2);

        // Directed vectors, applied back to back.
        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, st, dv);
            check("tbl_stalls", st, vecs[i].exp_stalls);
            check("tbl_din", dv, vecs[i].exp_din);
        end
        idle(2);

        // Randomized accesses over a few words so buffer hits and invalidations occur.
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [23:0] a;
            k = $urandom_range(0, 3);
            a = wbase[$urandom_range(0, 3)] | 24'($urandom_range(0, 3));
            case (k)
                0: idle($urandom_range(1, 3));
                1: access(1'b1, 4'h0, a, $urandom, st, dv);
                2: access(1'b0, 4'($urandom_range(1, 15)), a, $urandom, st, dv);
                default: access(1'b1, 4'($urandom_range(1, 15)), a, $urandom, st, dv);
            endcase
        end

        // Reset in the middle of a write strobe; the byte rewritten is unchanged.
        @(negedge i_clk);
        drive(1'b0, 4'b0001, 24'h000800, {24'h0, ref_mem[12'h800]});
        for (int c = 0; c < 20 && o_xwe_b; c++) @(negedge i_clk);
        check("mid_reached_strobe", o_xwe_b, 1'b0);
        #2 i_rstb = 1'b0;
        #1;
        check("mid_rst_xwe_b", o_xwe_b, 1'b1);
        check("mid_rst_xce_b", o_xce_b, 1'b1);
        check("mid_rst_xoe_b", o_xoe_b, 1'b1);
        check("mid_rst_xdata_oe", o_xdata_oe, 1'b0);
        check("mid_rst_din", cpu_bus.o_din, 32'h0);
        model_din   = 32'h0;
        model_valid = 1'b0;
        drive(1'b0, 4'h0, 24'h0, 32'h0);
        @(negedge i_clk);
        i_rstb = 1'b1;
        #1;
        check("post_rst_clk_en", cpu_bus.o_clk_en, 1'b1);
        idle(2);
        access(1'b1, 4'h0, 24'h000400, 32'h0, st, dv);
        access(1'b1, 4'h0, 24'h000400, 32'h0, st, dv);
        idle(2);

        mism = 0;
        for (int i = 0; i < 4096; i++) if (sram[i] !== ref_mem[i]) mism++;
        check("mem_image_mismatches", mism, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
